wave_capture: RTL and testbench
===============================

# wave_capture

Writer side of the double-buffered sample RAM that `wave_display` reads. Watches the audio sample stream and, on each rising zero crossing, captures 256 consecutive samples into the RAM half the display is not reading. It then waits for the display to go idle and flips `read_index` so the display shows the new capture. Sits between the codec/sample source and the 512×8 sample RAM write port.

## Interface
Parameters:
- `TIMEOUT_SAMPLES`, 1024 — samples spent in ARMED without a crossing before a forced trigger. Used only when `WAVE_CAPTURE_TIMEOUT_EN` is defined. Legal range 2..65535.

Ports:
- `clk` in 1 — system clock. One clock domain; all state is updated on the rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `new_sample_ready` in 1 — one-cycle strobe; `new_sample_in` is valid in that cycle.
- `new_sample_in` in 16 — signed two's-complement audio sample.
- `wave_display_idle` in 1 — high while the display is outside the active drawing region (vblank).
- `write_address` out 9 — RAM write address, `{~read_index, count[7:0]}`.
- `write_enable` out 1 — RAM write strobe, one cycle per captured sample.
- `write_sample` out 8 — offset-binary sample: `new_sample_in[15:8] ^ 8'h80`.
- `read_index` out 1 — RAM half the display reads. The capture always writes the other half.

## Operation
- States: ARMED, ACTIVE, WAIT. Reset state is ARMED.
- `prev_sample` holds the last sample seen. It is updated on every `new_sample_ready`, in every state.
- Rising crossing: `prev_sample[15]==1 && new_sample_in[15]==0`, evaluated on `new_sample_ready`.
- ARMED:
  - On a crossing, write the crossing sample at `count=0`, set `count=1`, and go to ACTIVE.
  - With no crossing, no write.
- ACTIVE:
  - On each `new_sample_ready`, write at `count`, then increment `count`.
  - The write at `count=255` moves to WAIT, and `count` wraps to 0.
- WAIT:
  - No writes.
  - When `wave_display_idle==1`, toggle `read_index`, clear `count`, and go to ARMED.
  - The toggle is level-triggered, so at most one toggle occurs per WAIT entry.
- A sample arriving in the same cycle as the WAIT→ARMED transition updates `prev_sample` only. It is not tested for a crossing.
- Reset asserted mid-capture:
  - All state returns to reset values immediately.
  - The partially written half is abandoned. It is not displayed until a full capture completes.
- Width rules:
  - `count` is 8 bits.
  - `write_sample` uses only the upper byte; no rounding.
  - `8'h80` represents zero.

## Timing
- Reset values:
  - State ARMED.
  - `read_index=0`, so the first capture writes addresses 256–511.
  - `write_enable=0`, `write_address=9'd0`, `write_sample=8'd0`, `count=0`, `prev_sample=16'd0`.
- All outputs are registered.
- `write_enable`, `write_address` and `write_sample` are valid in the cycle after the `new_sample_ready` cycle that caused the write. They are held for exactly one cycle.
- Back-to-back `new_sample_ready` strobes on consecutive cycles are supported. Each produces a write on the following cycle.
- `read_index` toggles on the edge where WAIT sees `wave_display_idle` high. The new value is visible the next cycle.
- `write_address` uses the `read_index` value that was current when the write was registered. No write ever targets the half being displayed.
- Full capture latency from trigger: 256 `new_sample_ready` strobes, then the WAIT duration, then 1 cycle to the `read_index` toggle.

## Configuration
- `WAVE_CAPTURE_TIMEOUT_EN` defined:
  - ARMED keeps a 16-bit counter of `new_sample_ready` strobes without a crossing. The counter is cleared on entry to ARMED.
  - When the counter reaches `TIMEOUT_SAMPLES-1` and another sample arrives without a crossing, that sample is treated as the trigger: written at `count=0`, then go to ACTIVE.
  - This lets DC or silent input still refresh the display.
- `WAVE_CAPTURE_TIMEOUT_EN` undefined:
  - No counter logic.
  - ARMED waits indefinitely for a real crossing.

## Test plan
- **Reset:** hold `reset=0` while strobing samples.
  - -> `write_enable` stays 0, `read_index=0`, `write_address=0`.
  - Release reset -> state ARMED.
- **Trigger and capture:** feed -100, then +50, then 255 samples of value 16'h1234, all with `idle=0`.
  - -> The first write is at address 256 with data `8'h80^8'h00=8'h80`; the remaining data is `8'h92`.
  - -> 256 writes total, the last at address 511.
  - -> No further writes.
  - -> `read_index` stays 0.
- **Flip:** after the capture above, raise `wave_display_idle`.
  - -> `read_index=1` one cycle later.
  - -> The next crossing writes starting at address 0.
- **Reset mid-capture:** pulse `reset` low after 100 writes.
  - -> Outputs return to reset values immediately.
  - -> The next capture restarts at address 256 with `read_index=0`.
- **Timeout, without macro:** feed 2000 samples of constant 16'h0400.
  - -> Zero writes.
- **Timeout, with macro** (`TIMEOUT_SAMPLES=256`): feed the same 2000 samples of 16'h0400.
  - -> The first write occurs on the 256th sample, at address 256 with data `8'h84`.
  - -> The capture completes.

Source files
------------

// File: rtl/wave_capture.sv
// Writer side of the double-buffered 512x8 sample RAM: captures 256 samples per rising zero crossing
// into the half not being displayed, then flips read_index during display idle. Optional: WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture #(
    parameter int unsigned TIMEOUT_SAMPLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        WAIT
    } state_t;

    state_t      state, state_next;
    logic [7:0]  count;
    logic [15:0] prev_sample;
    logic        crossing;
    logic        trigger;
    logic        write_now;

    assign crossing = prev_sample[15] & ~new_sample_in[15];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    logic [15:0] quiet_count;
    logic        timeout_hit;

    assign timeout_hit = (quiet_count == 16'(TIMEOUT_SAMPLES - 1));
    assign trigger     = new_sample_ready & (crossing | timeout_hit);

    // Held at zero outside ARMED, so every entry into ARMED starts a fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quiet_count <= 16'd0;
        end else if (state != ARMED) begin
            quiet_count <= 16'd0;
        end else if (new_sample_ready && !crossing) begin
            quiet_count <= quiet_count + 16'd1;
        end
    end
`else
    localparam int unsigned unused_timeout_samples = TIMEOUT_SAMPLES;
    assign trigger = new_sample_ready & crossing;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        state_next = state;
        write_now  = 1'b0;
        case (state)
            ARMED: begin
                if (trigger) begin
                    write_now  = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_now = 1'b1;
                    if (count == 8'hFF) state_next = WAIT;
                end
            end
            WAIT: begin
                if (wave_display_idle) state_next = ARMED;
            end
            default: state_next = ARMED;
        endcase
    end

    // count is always 0 in ARMED, so a trigger write lands at offset 0 without special casing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sample   <= 16'd0;
            count         <= 8'd0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            if (new_sample_ready) prev_sample <= new_sample_in;
            write_enable <= write_now;
            if (write_now) begin
                write_address <= {~read_index, count};
                write_sample  <= new_sample_in[15:8] ^ 8'h80;
                count         <= count + 8'd1;
            end
            if (state == WAIT && wave_display_idle) begin
                read_index <= ~read_index;
                count      <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: a per-sample reference model pushes expected RAM writes,
// a negedge monitor pops and compares them. Honours WAVE_CAPTURE_TIMEOUT_EN with TIMEOUT_SAMPLES=256.
module tb_wave_capture;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    wave_capture #(.TIMEOUT_SAMPLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .wave_display_idle(wave_display_idle),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  n_writes = 0;
    bit  grab_first = 0;
    logic [8:0] first_addr;
    logic [7:0] first_data;

    // Reference model: phase 0 = waiting for trigger, 1 = capturing, 2 = waiting for display idle.
    int          m_phase;
    int          m_n;
    int          m_quiet;
    logic        m_ri;
    logic [15:0] m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_n     = 0;
        m_quiet = 0;
        m_ri    = 1'b0;
        m_prev  = 16'd0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] offset_byte(input logic [15:0] s);
        int v;
        v = ($signed(s) >>> 8) + 128;
        return v[7:0];
    endfunction

    task automatic push_write(input int offset, input logic [15:0] s);
        wr_t w;
        w.addr = {~m_ri, offset[7:0]};
        w.data = offset_byte(s);
        exp_q.push_back(w);
    endtask

    // Caller is at a negedge; inputs are applied, the model advanced, and one clock consumed.
    task automatic step(input logic rdy, input logic [15:0] s, input logic idl);
        bit trig;
        new_sample_ready  = rdy;
        new_sample_in     = s;
        wave_display_idle = idl;
        if (reset) begin
            if (m_phase == 2 && idl) begin
                m_ri    = ~m_ri;
                m_phase = 0;
                m_quiet = 0;
            end else if (rdy) begin
                if (m_phase == 1) begin
                    push_write(m_n, s);
                    m_n++;
                    if (m_n == 256) m_phase = 2;
                end else if (m_phase == 0) begin
                    trig = ($signed(m_prev) < 0) && ($signed(s) >= 0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                    if (!trig) begin
                        if (m_quiet == TO - 1) trig = 1;
                        else m_quiet++;
                    end
`endif
                    if (trig) begin
                        push_write(0, s);
                        m_n     = 1;
                        m_phase = 1;
                    end
                end
            end
            if (rdy) m_prev = s;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (write_enable) begin
            n_writes++;
            if (grab_first) begin
                first_addr = write_address;
                first_data = write_sample;
                grab_first = 0;
            end
            check("write_half", {31'd0, write_address[8]}, {31'd0, ~read_index});
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h/%0h expected=none", write_address, write_sample);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_address", {23'd0, write_address}, {23'd0, w.addr});
                check("write_sample", {24'd0, write_sample}, {24'd0, w.data});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   {31'd0, write_enable},   32'd0);
        check({tag, "_addr"}, {23'd0, write_address},  32'd0);
        check({tag, "_data"}, {24'd0, write_sample},   32'd0);
        check({tag, "_ri"},   {31'd0, read_index},     32'd0);
    endtask

    initial begin
        int base;
        reset             = 1'b0;
        new_sample_ready  = 1'b0;
        new_sample_in     = 16'd0;
        wave_display_idle = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Samples strobed while held in reset must produce nothing.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'($urandom), 1'b0);
            check_reset_outputs("in_reset");
        end
        reset = 1'b1;
        step(1'b0, 16'd0, 1'b0);

        // Trigger on -100 -> +50, then 255 samples of 0x1234.
        base = n_writes;
        step(1'b1, 16'hFF9C, 1'b0);
        step(1'b1, 16'd50, 1'b0);
        for (int i = 0; i < 255; i++) step(1'b1, 16'h1234, 1'b0);
        repeat (5) step(1'b1, 16'h1234, 1'b0);
        check("capture_count", n_writes - base, 32'd256);
        check("capture_drained", exp_q.size(), 32'd0);
        check("ri_before_flip", {31'd0, read_index}, 32'd0);

        // Display goes idle: flip, then the next capture targets the lower half.
        step(1'b0, 16'd0, 1'b1);
        check("ri_after_flip", {31'd0, read_index}, {31'd0, m_ri});
        check("ri_flipped", {31'd0, read_index}, 32'd1);
        step(1'b0, 16'd0, 1'b0);
        step(1'b1, 16'hFFFB, 1'b0);
        step(1'b1, 16'd7, 1'b0);
        for (int i = 0; i < 98; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, 16'd0, 1'b0);
        check("partial_drained", exp_q.size(), 32'd0);

        // Reset mid-capture: outputs clear at once, next capture restarts in the upper half.
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 16'hFFFF, 1'b0);
        grab_first = 1;
        step(1'b1, 16'h0000, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        check("restart_addr", {23'd0, first_addr}, 32'd256);
        check("restart_data", {24'd0, first_data}, 32'h80);

        // Randomised traffic: gaps, sign changes, sporadic display idle.
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 15) == 0));
        repeat (2) step(1'b0, 16'd0, 1'b0);
        check("random_drained", exp_q.size(), 32'd0);
        check("random_ri", {31'd0, read_index}, {31'd0, m_ri});

        // Constant positive input: no crossing ever occurs.
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        base = n_writes;
        grab_first = 1;
        for (int i = 0; i < 2000; i++) step(1'b1, 16'h0400, 1'b0);
        repeat (2) step(1'b0, 16'd0, 1'b0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        check("timeout_writes", n_writes - base, 32'd256);
        check("timeout_addr", {23'd0, first_addr}, 32'd256);
        check("timeout_data", {24'd0, first_data}, 32'h84);
`else
        check("no_timeout_writes", n_writes - base, 32'd0);
        grab_first = 0;
`endif
        check("final_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
